// File: rtl/addrc_controller.sv
`default_nettype none
// ============================================================================
// Module      : addrc_controller
// Description : Sequences the add-round-constant datapath. Each line of a
//               64-line file is read, loaded and written back.
// Revision    : 1.0 - initial release
// ============================================================================
module addrc_controller #(
    parameter int LINES  = 64,
    parameter int LINE_W = 6,
    parameter int FILE_W = 10,
    parameter int ITER_W = 5,
    parameter int ROUNDS = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FILE_W-1:0] file_sel,
    input  logic [ITER_W-1:0] round_sel,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              read_file,
    output logic              write_reg,
    output logic              write_file,
    output logic [FILE_W-1:0] file_index,
    output logic [LINE_W-1:0] line_index,
    output logic [ITER_W-1:0] iteration
);

    localparam logic [LINE_W-1:0] c_LAST_LINE = LINE_W'(LINES - 1);
    localparam logic [ITER_W:0]   c_ROUNDS    = (ITER_W + 1)'(ROUNDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [FILE_W-1:0]   r_file_q,  w_file_d;
    logic [LINE_W-1:0]   r_line_q,  w_line_d;
    logic [ITER_W-1:0]   r_iter_q,  w_iter_d;
    logic                r_err_q,   w_err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= ST_IDLE;
            r_file_q  <= '0;
            r_line_q  <= '0;
            r_iter_q  <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_file_q  <= w_file_d;
            r_line_q  <= w_line_d;
            r_iter_q  <= w_iter_d;
            r_err_q   <= w_err_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_file_d  = r_file_q;
        w_line_d  = r_line_q;
        w_iter_d  = r_iter_q;
        w_err_d   = r_err_q;
        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_file_d = file_sel;
                    w_iter_d = round_sel;
                    w_line_d = '0;
                    // Out-of-range rounds skip the datapath entirely
                    if ({1'b0, round_sel} < c_ROUNDS) begin
                        w_state_d = ST_READ;
                    end else begin
                        w_err_d   = 1'b1;
                        w_state_d = ST_DONE;
                    end
                end
            end
            ST_READ:  w_state_d = ST_LOAD;
            ST_LOAD:  w_state_d = ST_WRITE;
            ST_WRITE: begin
                if (r_line_q == c_LAST_LINE) begin
                    w_state_d = ST_DONE;
                end else begin
                    w_line_d  = r_line_q + 1'b1;
                    w_state_d = ST_READ;
                end
            end
            ST_DONE: begin
                w_err_d   = 1'b0;
                w_state_d = ST_IDLE;
            end
            default:  w_state_d = ST_IDLE;
        endcase
    end

    // Moore outputs: decoded purely from registered state
    assign busy       = (r_state_q != ST_IDLE);
    assign done       = (r_state_q == ST_DONE);
    assign err        = (r_state_q == ST_DONE) && r_err_q;
    assign read_file  = (r_state_q == ST_READ);
    assign write_reg  = (r_state_q == ST_LOAD);
    assign write_file = (r_state_q == ST_WRITE);
    assign file_index = r_file_q;
    assign line_index = r_line_q;
    assign iteration  = r_iter_q;

endmodule
`default_nettype wire

// File: tb/tb_addrc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_addrc_controller
// Description : Scoreboard bench for addrc_controller; directed stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addrc_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] file_sel;
    logic [4:0] round_sel;
    logic       busy, done, err, read_file, write_reg, write_file;
    logic [9:0] file_index;
    logic [5:0] line_index;
    logic [4:0] iteration;

    addrc_controller dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .file_sel   (file_sel),
        .round_sel  (round_sel),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .read_file  (read_file),
        .write_reg  (write_reg),
        .write_file (write_file),
        .file_index (file_index),
        .line_index (line_index),
        .iteration  (iteration)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 read, 1 load, 2 write, 3 done
    typedef struct {
        int          kind;
        int          file;
        int          line;
        int          iter;
        int          err;
        int unsigned at;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_strobes"}, {read_file, write_reg, write_file}, 0);
        check({tag, "_file_index"}, file_index, 0);
        check({tag, "_line_index"}, line_index, 0);
        check({tag, "_iteration"}, iteration, 0);
    endtask

    task automatic push_op(input int unsigned e, input int file, input int round);
        if (round >= 24) begin
            sb.push_back('{kind: 3, file: file, line: 0, iter: round, err: 1, at: e});
        end else begin
            for (int l = 0; l < 64; l++)
                for (int ph = 0; ph < 3; ph++)
                    sb.push_back('{kind: ph, file: file, line: l, iter: round, err: 0,
                                   at: e + 3 * l + ph});
            sb.push_back('{kind: 3, file: file, line: 63, iter: round, err: 0, at: e + 192});
        end
    endtask

    // Call at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic issue(input int file, input int round, output int unsigned e);
        file_sel  = 10'(file);
        round_sel = 5'(round);
        start     = 1'b1;
        e         = cyc + 1;
        push_op(e, file, round);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_idle_timeout_pending", sb.size(), 0);
    endtask

    task automatic wait_cycle(input int unsigned target);
        for (int i = 0; i < 1000 && cyc < target; i++) @(negedge clk);
        check("wait_cycle_reached", cyc, target);
    endtask

    // Monitor: pops one expected item per strobe/done cycle
    bit after_done = 1'b0;
    always @(negedge clk) begin
        int   hot;
        int   kind;
        exp_t e;
        if (rst === 1'b1) begin
            if (after_done) check("busy_after_done", busy, 0);
            after_done = (done === 1'b1);
            hot  = int'(read_file) + int'(write_reg) + int'(write_file) + int'(done);
            kind = write_reg ? 1 : write_file ? 2 : done ? 3 : 0;
            if (err && !done) check("err_without_done", err, 0);
            if (hot > 1) begin
                check("strobe_one_hot", hot, 1);
            end else if (hot == 1) begin
                if (sb.size() == 0) begin
                    check("unexpected_output_kind", kind, 255);
                end else begin
                    e = sb.pop_front();
                    check("kind", kind, e.kind);
                    check("cycle", cyc, e.at);
                    check("file_index", file_index, e.file);
                    check("line_index", line_index, e.line);
                    check("iteration", iteration, e.iter);
                    check("busy", busy, 1);
                    if (kind == 3) check("err", err, e.err);
                end
            end
        end
    end

    initial begin
        int unsigned e;
        rst       = 1'b0;
        start     = 1'b0;
        file_sel  = '0;
        round_sel = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_all_zero("idle");
        end

        // Valid run with an ignored start at line 20
        issue(37, 5, e);
        wait_cycle(e + 60);
        check("line20_read", read_file, 1);
        file_sel = 10'd99;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        file_sel = 10'd37;
        wait_idle(400);
        check("hold_line_index", line_index, 63);
        check("hold_file_index", file_index, 37);
        check("hold_iteration", iteration, 5);

        // Out-of-range round
        @(negedge clk);
        issue(37, 24, e);
        wait_idle(10);
        check("err_run_line_index", line_index, 0);

        // Asynchronous reset during LOAD of line 12
        @(negedge clk);
        issue(12, 9, e);
        wait_cycle(e + 37);
        check("line12_load", write_reg, 1);
        check("line12_index", line_index, 12);
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(3, 23, e);
        wait_idle(400);

        // start held high: back-to-back runs one IDLE cycle apart
        @(negedge clk);
        file_sel  = 10'd5;
        round_sel = 5'd7;
        start     = 1'b1;
        e         = cyc + 1;
        push_op(e, 5, 7);
        push_op(e + 194, 5, 7);
        wait_cycle(e + 204);
        start = 1'b0;
        wait_idle(500);

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/addrc_controller.md
Name: addrc_controller

Overview:
- Sequencer for the add-round-constant (addRC) datapath.
- On a start request it latches a file index and a round number, then walks all 64 lines of the file. For each line it performs read, register load and write-back, then reports completion.
- It drives the datapath's read_file, write_reg, write_file, file_index, line_index and iteration inputs.
- It sits between the round-level encoder controller and the addRC datapath.

Parameters:
- LINES, 64, number of 25-bit pages (lines) per file; the last line index is LINES-1.
- LINE_W, 6, width of line_index.
- FILE_W, 10, width of file_index.
- ITER_W, 5, width of iteration.
- ROUNDS, 24, number of valid round numbers (0..ROUNDS-1).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets immediately, independent of clk).
- start  input  1  request to process one file; sampled only in IDLE.
- file_sel  input  FILE_W  file to process; latched when start is accepted.
- round_sel  input  ITER_W  round number; latched when start is accepted.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in the DONE state.
- err  output  1  valid while done=1; high when the round was out of range.
- read_file  output  1  to datapath; high in the READ state.
- write_reg  output  1  to datapath; high in the LOAD state.
- write_file  output  1  to datapath; high in the WRITE state.
- file_index  output  FILE_W  to datapath; registered copy of file_sel.
- line_index  output  LINE_W  to datapath; current line counter.
- iteration  output  ITER_W  to datapath; registered copy of round_sel.

Behaviour:
- Reset (rst=0, asynchronous):
  - state forced to IDLE.
  - file_index, line_index, iteration and the error register cleared to 0.
  - busy, done, err, read_file, write_reg and write_file all 0.
- Strobes: Moore outputs decoded from the state register only; no combinational path from any input to any output.
- Exactly one of read_file/write_reg/write_file is high in READ/LOAD/WRITE; none is high in other states.
- States and transitions:
  - IDLE: if start=1, latch file_sel→file_index and round_sel→iteration, and clear line_index to 0.
    - If round_sel < ROUNDS, go to READ.
    - Otherwise set the error register and go to DONE with no datapath access.
    - With start=0, stay in IDLE and hold all registers.
  - READ: read_file=1 for line line_index → LOAD.
  - LOAD: write_reg=1 (datapath register captures the read page) → WRITE.
  - WRITE: write_file=1 (datapath writes the page XORed with the round constant) → if line_index == LINES-1, go to DONE; otherwise increment line_index and go to READ.
  - DONE: done=1 and err = error register for this cycle → IDLE. The error register clears on exit.
- Timing:
  - 3 cycles per line; 192 cycles of datapath activity for LINES=64.
  - If start is accepted at edge k, READ of line 0 occupies cycle k+1 and DONE occupies cycle k+193.
  - For an out-of-range round, DONE occupies cycle k+1.
- line_index is constant across each READ/LOAD/WRITE triple. It changes only on the WRITE→READ edge.
  - It never wraps during an operation.
  - It holds LINES-1 in DONE and keeps that value in IDLE until the next accepted start.
- file_index and iteration hold their latched values from acceptance until the next accepted start.
  - Changing file_sel or round_sel while busy has no effect.
- start while busy=1 (including DONE) is ignored and not queued. A start held high through DONE is accepted in the following IDLE cycle.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The partially processed file is not completed and no done pulse is issued.
- round_sel = ROUNDS-1 (23) is valid. round_sel = ROUNDS (24) and above set err.

Test Plan:
- Reset, then hold idle → busy, done, err and all strobes stay 0; file_index, line_index and iteration read 0.
- start=1 for one cycle, file_sel=10'd37, round_sel=5'd5 →
  - read_file, write_reg, write_file pulse in sequence for lines 0..63, each with file_index=37 and iteration=5;
  - exactly 64 pulses of each strobe;
  - done=1 and err=0 exactly 193 cycles after the start edge; busy falls the next cycle.
- start with round_sel=5'd24 → no strobes; done=1 and err=1 one cycle after acceptance; then IDLE.
- During the previous valid run, pulse start with file_sel=10'd99 at line 20 → ignored; file_index stays 37 and the run completes normally.
- Drive rst=0 asynchronously during LOAD of line 12 → all outputs 0 before the next clk edge. A new start with round_sel=23 then runs from line 0 and completes with err=0.
- Hold start=1 continuously with fixed inputs → back-to-back operations separated by exactly one IDLE cycle; each produces one done pulse.
